// File: rtl/reg_pkg.sv
// Shared register-file constants, scope encodings and writeback source ids.
// Used by the writeback arbiter and its round-robin sub-block.
package reg_pkg;

   localparam int REG_IDX_W  = 4;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 16;

   localparam logic [1:0] SCOPE_NONE = 2'h0;
   localparam logic [1:0] SCOPE_LO   = 2'h1;
   localparam logic [1:0] SCOPE_HI   = 2'h2;
   localparam logic [1:0] SCOPE_FULL = 2'h3;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the pointer remembers the last granted source
// so that, under contention, the other source wins next.
module rr_arb2
   import reg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   src_e last;

   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == SRC_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Reset to "LSU went last" so the ALU wins the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         last <= SRC_LSU;
      end else if (gnt[0]) begin
         last <= SRC_ALU;
      end else if (gnt[1]) begin
         last <= SRC_LSU;
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file write port between the ALU and the load/store unit,
// registers the winning write and keeps the pending-write scoreboard for decode.
module reg_wb_arbiter
   import reg_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int IDX_W  = REG_IDX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 src0_valid,
   output logic                 src0_ready,
   input  logic [IDX_W-1:0]     src0_index,
   input  logic [DATA_W-1:0]    src0_data,
   input  logic [1:0]           src0_scope,
   input  logic                 src1_valid,
   output logic                 src1_ready,
   input  logic [IDX_W-1:0]     src1_index,
   input  logic [DATA_W-1:0]    src1_data,
   input  logic [1:0]           src1_scope,
   input  logic                 rsv_valid,
   input  logic [IDX_W-1:0]     rsv_index,
   output logic                 we,
   output logic [IDX_W-1:0]     reg_w_index,
   output logic [DATA_W-1:0]    wr_data,
   output logic [1:0]           wr_scope,
   output logic [2**IDX_W-1:0]  pending
);

   logic [1:0]          gnt;
   logic [IDX_W-1:0]    sel_index;
   logic [DATA_W-1:0]   sel_data;
   logic [1:0]          sel_scope;
   logic                accept;
   logic [2**IDX_W-1:0] pending_nxt;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({src1_valid, src0_valid}),
      .gnt (gnt)
   );

   assign src0_ready = gnt[0];
   assign src1_ready = gnt[1];

   // Zero-scope handshakes are consumed but never reach the register file.
   always_comb begin
      sel_index = src0_index;
      sel_data  = src0_data;
      sel_scope = src0_scope;
      if (gnt[1]) begin
         sel_index = src1_index;
         sel_data  = src1_data;
         sel_scope = src1_scope;
      end
      accept = (gnt != 2'b00) && (sel_scope != SCOPE_NONE);
   end

   // Clear first, then set, so a same-cycle reservation of the committing index survives.
   always_comb begin
      pending_nxt = pending;
      if (we) begin
         pending_nxt[reg_w_index] = 1'b0;
      end
      if (rsv_valid) begin
         pending_nxt[rsv_index] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we          <= 1'b0;
         reg_w_index <= '0;
         wr_data     <= '0;
         wr_scope    <= SCOPE_NONE;
         pending     <= '0;
      end else begin
         we      <= accept;
         pending <= pending_nxt;
         if (accept) begin
            reg_w_index <= sel_index;
            wr_data     <= sel_data;
            wr_scope    <= sel_scope;
         end
      end
   end

endmodule
